plru_array: RTL

Parametrised tree pseudo-LRU replacement state for a WAYS-way, SETS-set cache. It supersedes the fixed 4-way single-set PLRU. It adds per-set state, per-way valid tracking with invalid-way-first victim selection, and separate lookup and update ports with same-cycle forwarding. The block sits beside the tag/data arrays in the cache datapath. The cache controller queries it for a victim on a miss and touches or invalidates ways on hit, fill and flush.

---
 rtl/plru_pkg.sv | 27 ++
 rtl/plru_tree.sv | 53 +++++
 rtl/plru_array.sv | 80 ++++++++
 3 files changed

// File: rtl/plru_pkg.sv
// Shared types and heap-index helpers for the tree pseudo-LRU replacement state.
package plru_pkg;

  typedef enum logic {
    OP_TOUCH = 1'b0,
    OP_INV   = 1'b1
  } plru_op_e;

  // A binary tree over WAYS leaves has WAYS-1 internal nodes.
  function automatic int plru_nodes(input int ways);
    return ways - 1;
  endfunction

  function automatic int left_child(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int right_child(input int n);
    return 2 * n + 2;
  endfunction

  // Leaves follow the internal nodes in heap order, left to right.
  function automatic int leaf_to_way(input int n, input int ways);
    return n - plru_nodes(ways);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// One set's PLRU tree: next-state for touch/invalidate and victim selection from the input state.
module plru_tree
  import plru_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS),
  localparam int NODES = plru_nodes(WAYS)
) (
  input  logic [NODES-1:0] tree_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] way_i,
  input  logic             op_i,
  output logic [NODES-1:0] tree_o,
  output logic [WAYS-1:0]  valid_o,
  output logic [WAY_W-1:0] victim_o
);

  // Way index MSB picks the root branch; each level consumes one bit.
  always_comb begin
    int  node;
    logic dir;
    tree_o  = tree_i;
    valid_o = valid_i;
    node    = 0;
    dir     = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir          = way_i[WAY_W-1-l];
      tree_o[node] = (op_i == OP_INV) ? dir : ~dir;
      node         = dir ? right_child(node) : left_child(node);
    end
    valid_o[way_i] = (op_i == OP_TOUCH);
  end

  always_comb begin
    int               node;
    logic             any_inv;
    logic [WAY_W-1:0] inv_way;
    node    = 0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    for (int l = 0; l < WAY_W; l++) begin
      node = tree_i[node] ? right_child(node) : left_child(node);
    end
    victim_o = any_inv ? inv_way : WAY_W'(leaf_to_way(node, WAYS));
  end

endmodule

// File: rtl/plru_array.sv
// Per-set tree PLRU state with a registered victim lookup port and a write-first update port.
module plru_array
  import plru_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS),
  localparam int NODES = plru_nodes(WAYS)
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             csb0,
  input  logic [SET_W-1:0] addr0,
  output logic [WAY_W-1:0] dout0,
  output logic             vld0,
  input  logic             web1,
  input  logic             inv1,
  input  logic [SET_W-1:0] addr1,
  input  logic [WAY_W-1:0] din1
);

  logic [SETS-1:0][NODES-1:0] tree_q;
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [WAY_W-1:0]           dout_q, dout_d;
  logic                       vld_q;

  logic [NODES-1:0] upd_tree, lk_tree, lk_tree_nx;
  logic [WAYS-1:0]  upd_valid, lk_valid, lk_valid_nx;
  logic [WAY_W-1:0] upd_victim;
  logic             fwd;

  plru_tree #(.WAYS(WAYS)) u_upd (
    .tree_i  (tree_q[addr1]),
    .valid_i (valid_q[addr1]),
    .way_i   (din1),
    .op_i    (inv1),
    .tree_o  (upd_tree),
    .valid_o (upd_valid),
    .victim_o(upd_victim)
  );

  // Same-set update in the lookup cycle is seen by the lookup (write-first).
  assign fwd      = !web1 && (addr0 == addr1);
  assign lk_tree  = fwd ? upd_tree  : tree_q[addr0];
  assign lk_valid = fwd ? upd_valid : valid_q[addr0];

  plru_tree #(.WAYS(WAYS)) u_lk (
    .tree_i  (lk_tree),
    .valid_i (lk_valid),
    .way_i   ('0),
    .op_i    (OP_TOUCH),
    .tree_o  (lk_tree_nx),
    .valid_o (lk_valid_nx),
    .victim_o(dout_d)
  );

  logic unused_nx;
  assign unused_nx = ^{upd_victim, lk_tree_nx, lk_valid_nx};

  always_ff @(posedge clk0) begin
    if (!rst0) begin
      tree_q  <= '0;
      valid_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (!web1) begin
        tree_q[addr1]  <= upd_tree;
        valid_q[addr1] <= upd_valid;
      end
      if (!csb0) dout_q <= dout_d;
      vld_q <= !csb0;
    end
  end

  assign dout0 = dout_q;
  assign vld0  = vld_q;

endmodule
